calc_req_scheduler: RTL and testbench

//  Front-end scheduler that shares one single-issue calculator execution unit (exe) between 4 request ports.

---
 rtl/calc_req_scheduler.sv | 177 +++++++++++++++++
 tb/tb_calc_req_scheduler.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_req_scheduler.sv
// calc_req_scheduler: shares one exe unit between 4 two-cycle calc ports via per-port FIFOs,
// a round-robin registered issue stage and registered per-port response routing.
module calc_req_scheduler #(
  parameter int CMD_W  = 4,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 2,
  parameter int RESP_W = 2,
  parameter int QDEPTH = 4
) (
  input  logic                ifClk,
  input  logic                ifRst,
  input  logic [4*CMD_W-1:0]  req_cmd_in,
  input  logic [4*DATA_W-1:0] req_data_in,
  input  logic [4*TAG_W-1:0]  req_tag_in,
  output logic                exe_valid,
  input  logic                exe_ready,
  output logic [CMD_W-1:0]    exe_cmd,
  output logic [DATA_W-1:0]   exe_op1,
  output logic [DATA_W-1:0]   exe_op2,
  output logic [1:0]          exe_port,
  output logic [TAG_W-1:0]    exe_tag,
  input  logic                rsp_valid,
  input  logic [RESP_W-1:0]   rsp_code,
  input  logic [DATA_W-1:0]   rsp_data,
  input  logic [1:0]          rsp_port,
  input  logic [TAG_W-1:0]    rsp_tag,
  output logic [4*RESP_W-1:0] resp_out,
  output logic [4*DATA_W-1:0] data_out,
  output logic [4*TAG_W-1:0]  tag_out,
  output logic [3:0]          err_ovf,
  output logic [3:0]          err_proto,
  input  logic                err_clr
);
  localparam int AW = $clog2(QDEPTH);
  localparam int EW = CMD_W + TAG_W + 2*DATA_W;
  typedef enum logic {IDLE, OP2} cap_t;
  cap_t             st_q [4], st_d [4];
  logic [CMD_W-1:0] cmd_q [4], cmd_d [4];
  logic [TAG_W-1:0] tag_q [4], tag_d [4];
  logic [DATA_W-1:0] op1_q [4], op1_d [4];
  logic [EW-1:0]    mem_q [4][QDEPTH], mem_d [4][QDEPTH];
  logic [AW-1:0]    rd_q [4], rd_d [4], wr_q [4], wr_d [4];
  logic [AW:0]      cnt_q [4], cnt_d [4];
  logic             iv_q, iv_d;
  logic [EW-1:0]    ie_q, ie_d;
  logic [1:0]       ip_q, ip_d, last_q, last_d;
  logic [4*RESP_W-1:0] resp_q, resp_d;
  logic [4*DATA_W-1:0] data_q, data_d;
  logic [4*TAG_W-1:0]  rtag_q, rtag_d;
  logic [3:0]       ovf_q, ovf_d, proto_q, proto_d;
  logic [3:0]       push, elig, pop, new_ovf, new_proto;
  logic [EW-1:0]    pent [4], head [4];
  logic             load, found, wr_en, rd_en, bypass;
  logic [1:0]       gnt, idx;
  logic [CMD_W-1:0] c;
  always_comb begin
    st_d = st_q;
    cmd_d = cmd_q;
    tag_d = tag_q;
    op1_d = op1_q;
    mem_d = mem_q;
    rd_d = rd_q;
    wr_d = wr_q;
    cnt_d = cnt_q;
    new_ovf = '0;
    new_proto = '0;
    found = 1'b0;
    gnt = last_q;
    idx = last_q;
    wr_en = 1'b0;
    rd_en = 1'b0;
    bypass = 1'b0;
    c = '0;
    for (int p = 0; p < 4; p++) begin
      push[p] = st_q[p] == OP2;
      pent[p] = {cmd_q[p], tag_q[p], op1_q[p], req_data_in[p*DATA_W +: DATA_W]};
      elig[p] = cnt_q[p] != '0 || push[p];
      head[p] = cnt_q[p] != '0 ? mem_q[p][rd_q[p]] : pent[p];
    end
    load = !iv_q || exe_ready;
    for (int i = 1; i <= 4; i++) begin
      idx = last_q + 2'(i);
      if (!found && elig[idx]) begin
        found = 1'b1;
        gnt = idx;
      end
    end
    for (int p = 0; p < 4; p++) pop[p] = load && found && gnt == 2'(p);
    iv_d = load ? found : iv_q;
    ie_d = load && found ? head[gnt] : ie_q;
    ip_d = load && found ? gnt : ip_q;
    last_d = load && found ? gnt : last_q;
    for (int p = 0; p < 4; p++) begin
      // An entry popped the same edge it arrives into an empty FIFO never touches storage
      bypass = push[p] && pop[p] && cnt_q[p] == '0;
      wr_en = push[p] && !bypass && (cnt_q[p] != (AW+1)'(QDEPTH) || pop[p]);
      rd_en = pop[p] && cnt_q[p] != '0;
      new_ovf[p] = push[p] && cnt_q[p] == (AW+1)'(QDEPTH) && !pop[p];
      if (wr_en) mem_d[p][wr_q[p]] = pent[p];
      wr_d[p] = wr_q[p] + AW'(wr_en);
      rd_d[p] = rd_q[p] + AW'(rd_en);
      cnt_d[p] = cnt_q[p] + (AW+1)'(wr_en) - (AW+1)'(rd_en);
      c = req_cmd_in[p*CMD_W +: CMD_W];
      new_proto[p] = push[p] && c != '0;
      st_d[p] = st_q[p] == IDLE && c != '0 ? OP2 : IDLE;
      if (st_q[p] == IDLE && c != '0) begin
        cmd_d[p] = c;
        tag_d[p] = req_tag_in[p*TAG_W +: TAG_W];
        op1_d[p] = req_data_in[p*DATA_W +: DATA_W];
      end
    end
    ovf_d = (err_clr ? 4'd0 : ovf_q) | new_ovf;
    proto_d = (err_clr ? 4'd0 : proto_q) | new_proto;
    resp_d = '0;
    data_d = '0;
    rtag_d = '0;
    for (int p = 0; p < 4; p++) begin
      if (rsp_valid && rsp_port == 2'(p)) begin
        resp_d[p*RESP_W +: RESP_W] = rsp_code;
        data_d[p*DATA_W +: DATA_W] = rsp_data;
        rtag_d[p*TAG_W +: TAG_W] = rsp_tag;
      end
    end
  end
  always_ff @(posedge ifClk or negedge ifRst) begin
    if (!ifRst) begin
      for (int p = 0; p < 4; p++) begin
        st_q[p] <= IDLE;
        cmd_q[p] <= '0;
        tag_q[p] <= '0;
        op1_q[p] <= '0;
        rd_q[p] <= '0;
        wr_q[p] <= '0;
        cnt_q[p] <= '0;
        for (int e = 0; e < QDEPTH; e++) mem_q[p][e] <= '0;
      end
      iv_q <= 1'b0;
      ie_q <= '0;
      ip_q <= '0;
      last_q <= 2'd3;
      resp_q <= '0;
      data_q <= '0;
      rtag_q <= '0;
      ovf_q <= '0;
      proto_q <= '0;
    end else begin
      st_q <= st_d;
      cmd_q <= cmd_d;
      tag_q <= tag_d;
      op1_q <= op1_d;
      mem_q <= mem_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
      iv_q <= iv_d;
      ie_q <= ie_d;
      ip_q <= ip_d;
      last_q <= last_d;
      resp_q <= resp_d;
      data_q <= data_d;
      rtag_q <= rtag_d;
      ovf_q <= ovf_d;
      proto_q <= proto_d;
    end
  end
  assign exe_valid = iv_q;
  assign exe_cmd = ie_q[EW-1 -: CMD_W];
  assign exe_tag = ie_q[2*DATA_W +: TAG_W];
  assign exe_op1 = ie_q[DATA_W +: DATA_W];
  assign exe_op2 = ie_q[0 +: DATA_W];
  assign exe_port = ip_q;
  assign resp_out = resp_q;
  assign data_out = data_q;
  assign tag_out = rtag_q;
  assign err_ovf = ovf_q;
  assign err_proto = proto_q;
endmodule

// File: tb/tb_calc_req_scheduler.sv
// tb_calc_req_scheduler: directed sequences, a response-routing vector table and a random run,
// all checked every cycle against a queue-based transaction model of the scheduler.
module tb_calc_req_scheduler;
  logic         ifClk, ifRst;
  logic [15:0]  req_cmd_in;
  logic [127:0] req_data_in;
  logic [7:0]   req_tag_in;
  logic         exe_valid, exe_ready;
  logic [3:0]   exe_cmd;
  logic [31:0]  exe_op1, exe_op2;
  logic [1:0]   exe_port, exe_tag;
  logic         rsp_valid;
  logic [1:0]   rsp_code, rsp_port, rsp_tag;
  logic [31:0]  rsp_data;
  logic [7:0]   resp_out, tag_out;
  logic [127:0] data_out;
  logic [3:0]   err_ovf, err_proto;
  logic         err_clr;
  int n_cmp = 0, n_err = 0;
  calc_req_scheduler dut (
    .ifClk(ifClk), .ifRst(ifRst), .req_cmd_in(req_cmd_in), .req_data_in(req_data_in),
    .req_tag_in(req_tag_in), .exe_valid(exe_valid), .exe_ready(exe_ready), .exe_cmd(exe_cmd),
    .exe_op1(exe_op1), .exe_op2(exe_op2), .exe_port(exe_port), .exe_tag(exe_tag),
    .rsp_valid(rsp_valid), .rsp_code(rsp_code), .rsp_data(rsp_data), .rsp_port(rsp_port),
    .rsp_tag(rsp_tag), .resp_out(resp_out), .data_out(data_out), .tag_out(tag_out),
    .err_ovf(err_ovf), .err_proto(err_proto), .err_clr(err_clr)
  );
  initial ifClk = 1'b0;
  always #5 ifClk = ~ifClk;
  typedef struct packed {
    logic [3:0]  cmd;
    logic [1:0]  tag;
    logic [31:0] op1;
    logic [31:0] op2;
  } ent_t;
  ent_t q [4][$];
  bit   pend [4];
  ent_t cap [4];
  bit   m_iv;
  ent_t m_ie;
  int   m_ip, m_last;
  logic [7:0]   m_resp, m_tag;
  logic [127:0] m_data;
  logic [3:0]   m_ovf, m_proto;
  typedef struct {
    logic v; logic [1:0] code; logic [31:0] d; logic [1:0] port; logic [1:0] tag;
    logic [7:0] e_resp; logic [7:0] e_tag; logic [31:0] e_lane;
  } rv_t;
  rv_t rv [6];
  task automatic chk(input string nm, input logic [255:0] a, input logic [255:0] e);
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask
  function automatic logic [255:0] all_out();
    return {exe_valid, exe_cmd, exe_op1, exe_op2, exe_port, exe_tag, resp_out, data_out,
            tag_out, err_ovf, err_proto};
  endfunction
  task automatic model_reset();
    for (int p = 0; p < 4; p++) begin
      q[p].delete();
      pend[p] = 0;
      cap[p] = '0;
    end
    m_iv = 0; m_ie = '0; m_ip = 0; m_last = 3;
    m_resp = '0; m_tag = '0; m_data = '0; m_ovf = '0; m_proto = '0;
  endtask
  task automatic model_next();
    bit psh [4];
    ent_t pe [4];
    logic [3:0] novf, nprt, c;
    int g, pp;
    bit ld;
    novf = '0; nprt = '0; g = -1;
    for (int p = 0; p < 4; p++) begin
      psh[p] = pend[p];
      pe[p] = {cap[p].cmd, cap[p].tag, cap[p].op1, req_data_in[p*32 +: 32]};
    end
    ld = !m_iv || exe_ready;
    if (ld)
      for (int k = 1; k <= 4; k++) begin
        pp = (m_last + k) % 4;
        if (g < 0 && (q[pp].size() != 0 || psh[pp])) g = pp;
      end
    for (int p = 0; p < 4; p++)
      if (psh[p]) begin
        if (q[p].size() < 4 || g == p) q[p].push_back(pe[p]);
        else novf[p] = 1'b1;
      end
    if (ld) begin
      m_iv = g >= 0;
      if (g >= 0) begin
        m_ie = q[g].pop_front();
        m_ip = g;
        m_last = g;
      end
    end
    for (int p = 0; p < 4; p++) begin
      c = req_cmd_in[p*4 +: 4];
      if (pend[p]) begin
        pend[p] = 0;
        nprt[p] = c != 0;
      end else if (c != 0) begin
        pend[p] = 1;
        cap[p] = {c, req_tag_in[p*2 +: 2], req_data_in[p*32 +: 32], 32'd0};
      end
    end
    m_ovf = (err_clr ? 4'd0 : m_ovf) | novf;
    m_proto = (err_clr ? 4'd0 : m_proto) | nprt;
    m_resp = '0; m_data = '0; m_tag = '0;
    if (rsp_valid) begin
      m_resp[rsp_port*2 +: 2] = rsp_code;
      m_data[rsp_port*32 +: 32] = rsp_data;
      m_tag[rsp_port*2 +: 2] = rsp_tag;
    end
  endtask
  task automatic step();
    model_next();
    @(posedge ifClk);
    #1;
    chk("model_exe", {exe_valid, exe_valid ? {exe_cmd, exe_op1, exe_op2, exe_port, exe_tag} : 72'd0},
        {m_iv, m_iv ? {m_ie.cmd, m_ie.op1, m_ie.op2, 2'(m_ip), m_ie.tag} : 72'd0});
    chk("model_rsp", {resp_out, data_out, tag_out}, {m_resp, m_data, m_tag});
    chk("model_err", {err_ovf, err_proto}, {m_ovf, m_proto});
  endtask
  task automatic clr_in();
    req_cmd_in = '0; req_data_in = '0; req_tag_in = '0;
    rsp_valid = 0; rsp_code = '0; rsp_data = '0; rsp_port = '0; rsp_tag = '0; err_clr = 0;
  endtask
  task automatic drive(input int p, input logic [3:0] c, input logic [1:0] t, input logic [31:0] d);
    req_cmd_in[p*4 +: 4] = c;
    req_tag_in[p*2 +: 2] = t;
    req_data_in[p*32 +: 32] = d;
  endtask
  task automatic do_reset();
    clr_in();
    ifRst = 0;
    #1;
    chk("rst_outputs", all_out(), 256'd0);
    model_reset();
    #1;
    ifRst = 1;
  endtask
  initial begin
    int cnt, thr;
    clr_in();
    exe_ready = 1;
    ifRst = 0;
    repeat (3) @(posedge ifClk);
    #1;
    chk("rst_state", all_out(), 256'd0);
    model_reset();
    ifRst = 1;
    step();
    // T1 single request and its response
    drive(0, 4'd1, 2'd2, 32'd5); step();
    drive(0, 4'd0, 2'd0, 32'd3); step();
    chk("t1_issue", {exe_valid, exe_cmd, exe_op1, exe_op2, exe_port, exe_tag},
        {1'b1, 4'd1, 32'd5, 32'd3, 2'd0, 2'd2});
    drive(0, 4'd0, 2'd0, 32'd0);
    rsp_valid = 1; rsp_code = 2'd1; rsp_data = 32'd8; rsp_port = 2'd0; rsp_tag = 2'd2; step();
    chk("t1_resp", {resp_out, data_out, tag_out}, {8'd1, 128'd8, 8'd2});
    rsp_valid = 0; step();
    chk("t1_resp_clear", resp_out, 8'd0);
    // T2 round robin from reset, then a two-port wave
    do_reset();
    step();
    for (int p = 0; p < 4; p++) drive(p, 4'(p + 1), 2'(p), 32'(10 + p));
    step();
    for (int p = 0; p < 4; p++) drive(p, 4'd0, 2'd0, 32'(20 + p));
    step();
    clr_in();
    for (int k = 0; k < 4; k++) begin
      chk("t2_order", {exe_valid, exe_port, exe_op1, exe_op2}, {1'b1, 2'(k), 32'(10 + k), 32'(20 + k)});
      step();
    end
    chk("t2_drained", exe_valid, 1'b0);
    drive(2, 4'd5, 2'd1, 32'd42); drive(0, 4'd6, 2'd3, 32'd40); step();
    drive(2, 4'd0, 2'd0, 32'd43); drive(0, 4'd0, 2'd0, 32'd41); step();
    clr_in();
    chk("t2_wave_a", {exe_valid, exe_port, exe_op1}, {1'b1, 2'd0, 32'd40});
    step();
    chk("t2_wave_b", {exe_valid, exe_port, exe_op1}, {1'b1, 2'd2, 32'd42});
    step();
    // T3 backpressure: one held in the issue register, four queued, the sixth dropped
    exe_ready = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1, 4'd3, 2'(i), 32'(100 + i)); step();
      drive(1, 4'd0, 2'd0, 32'(200 + i)); step();
      chk("t3_hold", {exe_valid, exe_port, exe_op1, exe_op2}, {1'b1, 2'd1, 32'd100, 32'd200});
    end
    clr_in();
    chk("t3_ovf", err_ovf, 4'b0010);
    exe_ready = 1;
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      if (exe_valid) begin
        chk("t3_fifo_order", {exe_op1, exe_op2}, {32'(100 + cnt), 32'(200 + cnt)});
        cnt++;
      end
      step();
    end
    chk("t3_issue_count", cnt, 5);
    // T4 protocol error: cmd during the operand2 cycle is only flagged
    drive(3, 4'd2, 2'd1, 32'd9); step();
    drive(3, 4'd1, 2'd0, 32'd4); step();
    clr_in();
    chk("t4_proto", err_proto, 4'b1000);
    chk("t4_issue", {exe_valid, exe_cmd, exe_op1, exe_op2, exe_port, exe_tag},
        {1'b1, 4'd2, 32'd9, 32'd4, 2'd3, 2'd1});
    step();
    chk("t4_no_extra", exe_valid, 1'b0);
    err_clr = 1; step();
    err_clr = 0;
    chk("t4_clear", {err_ovf, err_proto}, 8'd0);
    // T5 push into a full FIFO on the same edge as its pop
    exe_ready = 0;
    for (int i = 0; i < 5; i++) begin
      drive(2, 4'd7, 2'd2, 32'(300 + i)); step();
      drive(2, 4'd0, 2'd0, 32'(400 + i)); step();
    end
    drive(2, 4'd7, 2'd2, 32'd305); step();
    exe_ready = 1;
    drive(2, 4'd0, 2'd0, 32'd405); step();
    clr_in();
    chk("t5_no_ovf", err_ovf, 4'b0000);
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      if (exe_valid) begin
        chk("t5_fifo_order", {exe_op1, exe_op2}, {32'(301 + cnt), 32'(401 + cnt)});
        cnt++;
      end
      step();
    end
    chk("t5_issue_count", cnt, 5);
    // Response routing vectors
    rv[0] = '{1'b1, 2'd1, 32'hAAAA0001, 2'd0, 2'd3, 8'b00000001, 8'b00000011, 32'hAAAA0001};
    rv[1] = '{1'b1, 2'd2, 32'h12345678, 2'd1, 2'd1, 8'b00001000, 8'b00000100, 32'h12345678};
    rv[2] = '{1'b1, 2'd1, 32'hDEADBEEF, 2'd2, 2'd2, 8'b00010000, 8'b00100000, 32'hDEADBEEF};
    rv[3] = '{1'b1, 2'd3, 32'hFFFFFFFF, 2'd3, 2'd3, 8'b11000000, 8'b11000000, 32'hFFFFFFFF};
    rv[4] = '{1'b0, 2'd1, 32'h00000077, 2'd1, 2'd1, 8'b00000000, 8'b00000000, 32'h00000000};
    rv[5] = '{1'b1, 2'd0, 32'h00000005, 2'd3, 2'd1, 8'b00000000, 8'b01000000, 32'h00000005};
    for (int i = 0; i < 6; i++) begin
      rsp_valid = rv[i].v; rsp_code = rv[i].code; rsp_data = rv[i].d;
      rsp_port = rv[i].port; rsp_tag = rv[i].tag;
      step();
      chk("vec_resp", resp_out, rv[i].e_resp);
      chk("vec_tag", tag_out, rv[i].e_tag);
      chk("vec_data", data_out, 128'(rv[i].e_lane) << (32 * rv[i].port));
    end
    clr_in(); step();
    // T6 asynchronous reset during an OP2 cycle with an issue pending
    exe_ready = 0;
    drive(1, 4'd1, 2'd0, 32'd50); step();
    drive(1, 4'd0, 2'd0, 32'd51); step();
    drive(1, 4'd0, 2'd0, 32'd0);
    drive(0, 4'd4, 2'd1, 32'd7); step();
    chk("t6_pre", exe_valid, 1'b1);
    drive(0, 4'd0, 2'd0, 32'd8);
    do_reset();
    exe_ready = 1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t6_no_stale", exe_valid, 1'b0);
    end
    rsp_valid = 1; rsp_code = 2'd1; rsp_data = 32'd77; rsp_port = 2'd2; rsp_tag = 2'd1; step();
    chk("t6_rsp_routed", {resp_out, data_out[95:64], tag_out}, {8'b00010000, 32'd77, 8'b00010000});
    clr_in();
    // Random traffic with shifting backpressure
    thr = 80;
    for (int n = 0; n < 3000; n++) begin
      if (n % 400 == 0) thr = (n / 400) % 2 == 1 ? 15 : 85;
      for (int p = 0; p < 4; p++)
        drive(p, $urandom_range(0, 3) == 0 ? 4'($urandom_range(1, 15)) : 4'd0,
              2'($urandom_range(0, 3)), $urandom);
      exe_ready = $urandom_range(0, 99) < thr;
      rsp_valid = $urandom_range(0, 2) == 0;
      rsp_code = 2'($urandom_range(0, 3)); rsp_data = $urandom;
      rsp_port = 2'($urandom_range(0, 3)); rsp_tag = 2'($urandom_range(0, 3));
      err_clr = $urandom_range(0, 39) == 0;
      step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
